// File: rtl/mem_ctrl_burst.sv
// Burst memory controller: 2**ADDR_W x DATA_W on-chip RAM behind a request/ready
// handshake, with flow-controlled write beats and a one-cycle-latency read stream.
module mem_ctrl_burst #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 3,
  parameter int LEN_W          = 3,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [LEN_W:0]      remaining;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_fire;
  logic                last_beat;

  always_comb begin
    wr_fire   = (state == WRITE) && wr_valid;
    last_beat = (remaining == (LEN_W+1)'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
      end
    end else if (wr_fire) begin
      mem[ptr] <= wr_data;
    end
  end

  // Handshake flags are registered alongside state, so req_ready rises the
  // cycle after reset releases and in the first IDLE cycle after a burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      req_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            ptr       <= req_addr;
            remaining <= {1'b0, req_len} + 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_we) begin
              state    <= WRITE;
              wr_ready <= 1'b1;
            end else begin
              state <= READ;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (last_beat) begin
              state     <= IDLE;
              wr_ready  <= 1'b0;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end
          end
        end
        READ: begin
          rd_data   <= mem[ptr];
          rd_valid  <= 1'b1;
          rd_last   <= last_beat;
          ptr       <= ptr + 1'b1;
          remaining <= remaining - 1'b1;
          if (last_beat) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
